// File: rtl/hamming_mem_ctrl.sv
// hamming_mem_ctrl: sequences a 7-bit Hamming(7,4) protected synchronous RAM
// behind a 4-bit req/ready/done word interface.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req, we, addr, wdata  request strobe, direction, word address, write data
//   ready                 high only while idle (request can be accepted)
//   done                  one-cycle completion pulse
//   rdata                 corrected read data, held until next read completes
//   corrected, err_pos    last read had a nonzero syndrome / its syndrome value
//   err_count             saturating count of corrected reads
//   ram_addr, ram_din     RAM address / codeword to write
//   ram_rw, ram_oe        RAM write enable (1 = write) / output enable
//   ram_dout              RAM read data (registered inside the RAM)
module hamming_mem_ctrl #(
  parameter int unsigned L     = 16,
  parameter int unsigned SCRUB = 1,
  localparam int unsigned AW   = (L > 1) ? $clog2(L) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    wdata,
  output logic          ready,
  output logic          done,
  output logic [3:0]    rdata,
  output logic          corrected,
  output logic [2:0]    err_pos,
  output logic [7:0]    err_count,
  output logic [AW-1:0] ram_addr,
  output logic [6:0]    ram_din,
  output logic          ram_rw,
  output logic          ram_oe,
  input  logic [6:0]    ram_dout
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WR   = 3'd1;
  localparam logic [2:0] S_RD   = 3'd2;
  localparam logic [2:0] S_CAP  = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  // Codeword bit i holds Hamming position i+1.
  function automatic logic [6:0] encode(input logic [3:0] d);
    logic p1, p2, p4;
    p1 = d[0] ^ d[1] ^ d[3];
    p2 = d[0] ^ d[2] ^ d[3];
    p4 = d[1] ^ d[2] ^ d[3];
    encode = {d[3], d[2], d[1], p4, d[0], p2, p1};
  endfunction

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [6:0]    ram_din_q, ram_din_d;
  logic          ram_rw_q, ram_rw_d;
  logic          ram_oe_q, ram_oe_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;
  logic [3:0]    rdata_q, rdata_d;
  logic          corrected_q, corrected_d;
  logic [2:0]    err_pos_q, err_pos_d;
  logic [7:0]    err_count_q, err_count_d;

  // Syndrome decode of the codeword currently presented by the RAM.
  logic [2:0] syn;
  logic [6:0] flip;
  logic [6:0] fixed_cw;

  always_comb begin
    syn[0] = ram_dout[0] ^ ram_dout[2] ^ ram_dout[4] ^ ram_dout[6];
    syn[1] = ram_dout[1] ^ ram_dout[2] ^ ram_dout[5] ^ ram_dout[6];
    syn[2] = ram_dout[3] ^ ram_dout[4] ^ ram_dout[5] ^ ram_dout[6];
    flip   = 7'h00;
    if (syn != 3'd0) begin
      flip[syn - 3'd1] = 1'b1;
    end
    fixed_cw = ram_dout ^ flip;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    ram_din_d   = ram_din_q;
    rdata_d     = rdata_q;
    corrected_d = corrected_q;
    err_pos_d   = err_pos_q;
    err_count_d = err_count_q;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d = addr;
          if (we) begin
            state_d     = S_WR;
            ram_din_d   = encode(wdata);
            corrected_d = 1'b0;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_WR:  state_d = S_DONE;
      S_RD:  state_d = S_CAP;
      S_CAP: begin
        rdata_d     = {fixed_cw[6], fixed_cw[5], fixed_cw[4], fixed_cw[2]};
        err_pos_d   = syn;
        corrected_d = (syn != 3'd0);
        if ((syn != 3'd0) && (err_count_q != 8'hFF)) begin
          err_count_d = err_count_q + 8'd1;
        end
        if ((SCRUB != 0) && (syn != 3'd0)) begin
          state_d   = S_WB;
          ram_din_d = fixed_cw;
        end else begin
          state_d = S_DONE;
        end
      end
      S_WB:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Strobes are registered from the state being entered so they align with it.
    ready_d  = (state_d == S_IDLE);
    done_d   = (state_d == S_DONE);
    ram_rw_d = (state_d == S_WR) || (state_d == S_WB);
    ram_oe_d = (state_d == S_CAP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      ram_din_q   <= 7'h00;
      ram_rw_q    <= 1'b0;
      ram_oe_q    <= 1'b0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      rdata_q     <= 4'h0;
      corrected_q <= 1'b0;
      err_pos_q   <= 3'd0;
      err_count_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      ram_din_q   <= ram_din_d;
      ram_rw_q    <= ram_rw_d;
      ram_oe_q    <= ram_oe_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
      corrected_q <= corrected_d;
      err_pos_q   <= err_pos_d;
      err_count_q <= err_count_d;
    end
  end

  assign ready     = ready_q;
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign corrected = corrected_q;
  assign err_pos   = err_pos_q;
  assign err_count = err_count_q;
  assign ram_addr  = addr_q;
  assign ram_din   = ram_din_q;
  assign ram_rw    = ram_rw_q;
  assign ram_oe    = ram_oe_q;

endmodule

// File: tb/tb_hamming_mem_ctrl.sv
// Self-checking bench for hamming_mem_ctrl with a behavioural RAM that can
// flip one chosen bit of the codeword on read (force_pos = 7 means no flip).
module tb_hamming_mem_ctrl;
  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req = 1'b0;
  logic          we = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [3:0]    wdata = 4'h0;
  logic          ready, done, corrected, ram_rw, ram_oe;
  logic [3:0]    rdata;
  logic [2:0]    err_pos;
  logic [7:0]    err_count;
  logic [AW-1:0] ram_addr;
  logic [6:0]    ram_din, ram_dout;

  int checks = 0;
  int failures = 0;
  int exp_count = 0;
  int force_pos = 7;
  logic [3:0] mem_model [16];

  always #5 clk = ~clk;

  hamming_mem_ctrl #(.L(16), .SCRUB(1)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ready(ready), .done(done), .rdata(rdata), .corrected(corrected),
    .err_pos(err_pos), .err_count(err_count), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_rw(ram_rw), .ram_oe(ram_oe), .ram_dout(ram_dout)
  );

  function automatic logic [6:0] flip_of(input int p);
    flip_of = 7'h00;
    if (p >= 0 && p < 7) flip_of[p] = 1'b1;
  endfunction

  // Behavioural RAM: registered read buffer refreshed on every rw=0 edge.
  logic [6:0] ram [16];
  logic [6:0] rbuf;
  always @(posedge clk) begin
    if (ram_rw) ram[ram_addr] <= ram_din;
    else        rbuf <= ram[ram_addr] ^ flip_of(force_pos);
  end
  assign ram_dout = ram_oe ? rbuf : 7'h00;

  // Hamming encode from first principles: data at non-power-of-two positions,
  // each parity position covers every position whose index has that bit set.
  function automatic logic [6:0] model_encode(input logic [3:0] d);
    int dpos [4] = '{3, 5, 6, 7};
    logic [6:0] cw = 7'h00;
    logic par;
    for (int i = 0; i < 4; i++) cw[dpos[i]-1] = d[i];
    for (int k = 0; k < 3; k++) begin
      par = 1'b0;
      for (int i = 0; i < 4; i++) if ((dpos[i] & (1 << k)) != 0) par = par ^ d[i];
      cw[(1 << k) - 1] = par;
    end
    return cw;
  endfunction

  // Issue one request; report cycles to done (0 = timeout) and any RAM write seen.
  task automatic op(input logic w, input logic [AW-1:0] a, input logic [3:0] d,
                    output int lat, output logic [6:0] wdin, output logic saw_rw);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk);
    #1 req = 1'b0;
    lat = 0; wdin = 7'h00; saw_rw = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (ram_rw) begin saw_rw = 1'b1; wdin = ram_din; end
      if (done) begin lat = i; break; end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({ready, done, rdata, corrected, err_pos, err_count} !== {1'b1, 1'b0, 4'h0, 1'b0, 3'd0, 8'd0}) begin
      failures++;
      $display("FAIL reset_status got=%b exp=%b", {ready, done, rdata, corrected, err_pos, err_count},
               {1'b1, 1'b0, 4'h0, 1'b0, 3'd0, 8'd0});
    end
    checks++;
    if ({ram_rw, ram_oe, ram_addr, ram_din} !== {1'b0, 1'b0, 4'h0, 7'h00}) begin
      failures++;
      $display("FAIL reset_ram_if got=%b exp=0", {ram_rw, ram_oe, ram_addr, ram_din});
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle ready=%b done=%b exp ready=1 done=0", ready, done);
    end
  endtask

  task automatic test_fill;
    int lat; logic [6:0] wdin; logic saw;
    logic [3:0] d;
    for (int a = 0; a < 16; a++) begin
      d = 4'($urandom);
      op(1'b1, 4'(a), d, lat, wdin, saw);
      mem_model[a] = d;
      checks++;
      if (lat != 2 || wdin !== model_encode(d)) begin
        failures++;
        $display("FAIL fill_write a=%0d lat=%0d din=%h exp lat=2 din=%h", a, lat, wdin, model_encode(d));
      end
    end
  endtask

  task automatic test_write_clean_read;
    int lat; logic [6:0] wdin; logic saw;
    op(1'b1, 4'd3, 4'hA, lat, wdin, saw);
    mem_model[3] = 4'hA;
    checks++;
    if (wdin !== 7'h52 || wdin !== model_encode(4'hA)) begin
      failures++;
      $display("FAIL wr_codeword got=%h exp=52", wdin);
    end
    checks++;
    if (lat != 2) begin failures++; $display("FAIL wr_latency got=%0d exp=2", lat); end
    force_pos = 7;
    op(1'b0, 4'd3, 4'h0, lat, wdin, saw);
    checks++;
    if (rdata !== 4'hA || corrected !== 1'b0 || err_pos !== 3'd0) begin
      failures++;
      $display("FAIL clean_read rdata=%h corr=%b pos=%0d exp A/0/0", rdata, corrected, err_pos);
    end
    checks++;
    if (lat != 3 || saw !== 1'b0) begin
      failures++;
      $display("FAIL clean_rd_latency lat=%0d wb=%b exp 3/0", lat, saw);
    end
  endtask

  task automatic test_single_error;
    int lat; logic [6:0] wdin; logic saw;
    force_pos = 4;
    op(1'b0, 4'd3, 4'h0, lat, wdin, saw);
    exp_count = (exp_count < 255) ? exp_count + 1 : 255;
    checks++;
    if (rdata !== 4'hA || corrected !== 1'b1 || err_pos !== 3'd5) begin
      failures++;
      $display("FAIL single_err rdata=%h corr=%b pos=%0d exp A/1/5", rdata, corrected, err_pos);
    end
    checks++;
    if (err_count !== 8'(exp_count)) begin
      failures++;
      $display("FAIL single_err_count got=%0d exp=%0d", err_count, exp_count);
    end
    checks++;
    if (lat != 4 || saw !== 1'b1 || wdin !== 7'h52) begin
      failures++;
      $display("FAIL scrub lat=%0d wb=%b din=%h exp 4/1/52", lat, saw, wdin);
    end
    force_pos = 7;
    checks++;
    if (ram[3] !== 7'h52) begin
      failures++;
      $display("FAIL scrub_ram_content got=%h exp=52", ram[3]);
    end
  endtask

  task automatic test_all_positions;
    int lat; logic [6:0] wdin; logic saw;
    op(1'b1, 4'd5, 4'h5, lat, wdin, saw);
    mem_model[5] = 4'h5;
    checks++;
    if (wdin !== 7'h2D) begin failures++; $display("FAIL wr_5_codeword got=%h exp=2d", wdin); end
    for (int p = 0; p < 7; p++) begin
      force_pos = p;
      op(1'b0, 4'd5, 4'h0, lat, wdin, saw);
      exp_count = (exp_count < 255) ? exp_count + 1 : 255;
      checks++;
      if (rdata !== 4'h5 || err_pos !== 3'(p + 1) || lat != 4) begin
        failures++;
        $display("FAIL pos_err p=%0d rdata=%h pos=%0d lat=%0d exp 5/%0d/4", p, rdata, err_pos, lat, p + 1);
      end
    end
    force_pos = 7;
  endtask

  task automatic test_handshake;
    logic rdy [1:10];
    logic dn  [1:10];
    int ndone;
    force_pos = 7;
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 4'd3;
    @(posedge clk);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      rdy[i] = ready; dn[i] = done;
      if (i == 7) req = 1'b0;
    end
    checks++;
    if (rdy[1] !== 1'b0 || rdy[2] !== 1'b0 || rdy[3] !== 1'b0 || rdy[4] !== 1'b1 || rdy[5] !== 1'b0) begin
      failures++;
      $display("FAIL hs_ready got=%b%b%b%b%b exp=00010", rdy[1], rdy[2], rdy[3], rdy[4], rdy[5]);
    end
    ndone = 0;
    for (int i = 1; i <= 10; i++) if (dn[i] === 1'b1) ndone++;
    checks++;
    if (ndone != 2 || dn[3] !== 1'b1 || dn[7] !== 1'b1) begin
      failures++;
      $display("FAIL hs_done count=%0d d3=%b d7=%b exp 2/1/1", ndone, dn[3], dn[7]);
    end
    checks++;
    if (rdata !== mem_model[3]) begin
      failures++;
      $display("FAIL hs_rdata got=%h exp=%h", rdata, mem_model[3]);
    end
  endtask

  task automatic test_reset_mid_read;
    int lat; logic [6:0] wdin; logic saw;
    force_pos = 4;
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 4'd3;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (ram_oe !== 1'b1) begin failures++; $display("FAIL cap_oe got=%b exp=1", ram_oe); end
    rst_n = 1'b0;
    #1;
    exp_count = 0;
    checks++;
    if (ready !== 1'b1 || done !== 1'b0 || ram_oe !== 1'b0 || err_count !== 8'd0) begin
      failures++;
      $display("FAIL mid_reset ready=%b done=%b oe=%b cnt=%0d exp 1/0/0/0", ready, done, ram_oe, err_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    force_pos = 7;
    op(1'b0, 4'd3, 4'h0, lat, wdin, saw);
    checks++;
    if (rdata !== mem_model[3] || lat != 3) begin
      failures++;
      $display("FAIL after_reset_read rdata=%h lat=%0d exp %h/3", rdata, lat, mem_model[3]);
    end
  endtask

  task automatic test_random;
    int lat; logic [6:0] wdin; logic saw;
    logic w; logic [3:0] a, d;
    for (int n = 0; n < 40; n++) begin
      w = 1'($urandom);
      a = 4'($urandom);
      d = 4'($urandom);
      if (w) begin
        op(1'b1, a, d, lat, wdin, saw);
        mem_model[a] = d;
        checks++;
        if (lat != 2 || wdin !== model_encode(d) || corrected !== 1'b0) begin
          failures++;
          $display("FAIL rnd_write a=%0d lat=%0d din=%h corr=%b exp 2/%h/0", a, lat, wdin, corrected, model_encode(d));
        end
      end else begin
        force_pos = int'($urandom_range(0, 7));
        op(1'b0, a, 4'h0, lat, wdin, saw);
        if (force_pos < 7) exp_count = (exp_count < 255) ? exp_count + 1 : 255;
        checks++;
        if (rdata !== mem_model[a] || err_pos !== 3'((force_pos < 7) ? force_pos + 1 : 0) ||
            corrected !== (force_pos < 7) || err_count !== 8'(exp_count) ||
            lat != ((force_pos < 7) ? 4 : 3)) begin
          failures++;
          $display("FAIL rnd_read a=%0d fp=%0d rdata=%h pos=%0d corr=%b cnt=%0d lat=%0d exp rdata=%h cnt=%0d",
                   a, force_pos, rdata, err_pos, corrected, err_count, lat, mem_model[a], exp_count);
        end
      end
    end
    force_pos = 7;
  endtask

  task automatic test_saturation;
    int lat; logic [6:0] wdin; logic saw;
    for (int n = 0; n < 260; n++) begin
      force_pos = int'($urandom_range(0, 6));
      op(1'b0, 4'd3, 4'h0, lat, wdin, saw);
      exp_count = (exp_count < 255) ? exp_count + 1 : 255;
    end
    force_pos = 7;
    checks++;
    if (err_count !== 8'd255 || exp_count != 255) begin
      failures++;
      $display("FAIL saturation got=%0d exp=255", err_count);
    end
    checks++;
    if (rdata !== mem_model[3]) begin
      failures++;
      $display("FAIL sat_rdata got=%h exp=%h", rdata, mem_model[3]);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_write_clean_read();
    test_single_error();
    test_all_positions();
    test_handshake();
    test_reset_mid_read();
    test_random();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hamming_mem_ctrl.md
Name: hamming_mem_ctrl

Overview:
- Sequences a 7-bit-wide, L-deep synchronous RAM with a registered read path and an output enable. The RAM stores Hamming(7,4) codewords and a read may return a codeword with at most one flipped bit.
- Presents a 4-bit word interface to a requester using a req/ready/done handshake.
- Encodes on write. Syndrome-decodes and corrects on read. Optionally writes the corrected codeword back (scrub). Keeps a count of corrected reads.

Parameters:
- L, 16, RAM depth in words; address width AW = $clog2(L)
- SCRUB, 1, 1 = write the corrected codeword back after any read with a nonzero syndrome; 0 = no write-back

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  1  request strobe, sampled only while ready=1
- we  in  1  1 = write, 0 = read
- addr  in  AW  word address
- wdata  in  4  write data
- ready  out  1  1 only in IDLE
- done  out  1  one-cycle pulse when an operation completes
- rdata  out  4  corrected read data, held until the next read completes
- corrected  out  1  valid with done on a read: syndrome was nonzero
- err_pos  out  3  syndrome of the last read (0 = clean, 1..7 = codeword position corrected)
- err_count  out  8  saturating count of corrected reads
- ram_addr  out  AW  RAM address
- ram_din  out  7  RAM write data (codeword)
- ram_rw  out  1  RAM write enable, 1 = write
- ram_oe  out  1  RAM output enable
- ram_dout  in  7  RAM read data

Behaviour:
- Reset (asynchronous, on rst_n=0):
  - state = IDLE
  - done=0, rdata=0, corrected=0, err_pos=0, err_count=0
  - ram_rw=0, ram_oe=0, ram_addr=0, ram_din=0
  - Reset mid-operation abandons the operation with no done pulse. RAM contents are not touched.
- Codeword layout: bit i holds Hamming position i+1.
  - cw[0]=p1, cw[1]=p2, cw[2]=d0, cw[3]=p4, cw[4]=d1, cw[5]=d2, cw[6]=d3
  - p1=d0^d1^d3, p2=d0^d2^d3, p4=d1^d2^d3
- Syndrome: s1=cw0^cw2^cw4^cw6, s2=cw1^cw2^cw5^cw6, s4=cw3^cw4^cw5^cw6; s={s4,s2,s1}.
  - If s≠0, invert cw[s-1].
  - Data = {cw6,cw5,cw4,cw2}.
- Handshake:
  - A request is accepted on an edge where state=IDLE and req=1. addr, we and wdata are registered at that edge.
  - req is ignored outside IDLE. There is no queueing.
- FSM states: IDLE, WR, RD, CAP, WB, DONE.
  - IDLE → WR if req&we; IDLE → RD if req&~we.
  - WR: ram_rw=1, ram_din=encode(wdata_reg). The RAM writes at the end of this cycle. WR → DONE.
  - RD: ram_rw=0, ram_addr=addr_reg. The RAM loads its read buffer at the end of this cycle. RD → CAP.
  - CAP: ram_oe=1, ram_rw=0. At the end of this cycle latch ram_dout and update rdata, err_pos and corrected. If s≠0, increment err_count (saturating at 255).
    - CAP → WB if SCRUB=1 and s≠0; otherwise CAP → DONE.
  - WB: ram_rw=1, ram_din=corrected codeword. WB → DONE.
  - DONE: done=1 for this one cycle. DONE → IDLE.
- Outside the states named above: ram_rw=0 and ram_oe=0. ram_addr always equals addr_reg.
- Latency from the acceptance edge to done=1:
  - write: 2 cycles
  - clean read: 3 cycles
  - read with write-back: 4 cycles
- corrected is cleared at the acceptance of every write.
- A RAM that re-reads on every rw=0 edge is tolerated because the value is captured only at the end of CAP.
- Double-bit errors are out of scope. They decode silently to the miscorrected data.

Test Plan:
- The bench uses a behavioural RAM model with a forced error position (7 = no error).
- Write then clean read: write addr=3, wdata=4'hA.
  - Required: ram_din=7'h52 during WR; done 2 cycles after acceptance.
  - Read addr=3: rdata=4'hA, corrected=0, err_pos=0, done 3 cycles after acceptance.
- Single-bit error: same word, force a flip of bit 4.
  - Required: rdata=4'hA, corrected=1, err_pos=5, err_count increments by 1.
  - With SCRUB=1: WB cycle with ram_rw=1, ram_din=7'h52; done 4 cycles after acceptance.
- Error on every position: force flips of bits 0..6 on consecutive reads of wdata=4'h5 (codeword 7'h2D).
  - Required: rdata=4'h5 each time; err_pos=1..7.
- Handshake: hold req=1 across a whole operation.
  - Required: ready=0 from RD through DONE; exactly one done per acceptance; the next request is accepted on the edge after DONE.
- Reset mid-read: assert rst_n=0 during CAP.
  - Required: ready=1, done=0, ram_oe=0, err_count=0 immediately.
  - After reset, a read of a previously written address returns the original data.
- Saturation: 260 reads with forced errors → err_count=255.
